dcache_mem_stage: RTL and testbench
===================================

# dcache_mem_stage

Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage, sitting directly upstream of the MEM/WB pipeline register. It serves loads and stores from EX/MEM, supplies load data on `M_DM_Read_Data`, and talks to a slow backing memory through a req/ready handshake. While a miss or write-through is outstanding it raises `stall`, which drives the MEM/WB hold input (`MWBWrite`) and the upstream pipeline stalls.

## Interface
- `data_size`, 32, data word width
- `addr_size`, 16, byte-address width
- `index_bits`, 4, line index width; 2^index_bits one-word lines
- `clk` in 1: single clock; all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `M_MemRead` in 1: load in MEM stage
- `M_MemWrite` in 1: store in MEM stage
- `M_Addr` in addr_size: byte address; bits [1:0] ignored
- `M_Write_Data` in data_size: store data
- `M_DM_Read_Data` out data_size: load data, to MEM/WB
- `stall` out 1: hold pipeline, to `MWBWrite` and upstream stages
- `mem_req` out 1: backing-memory request
- `mem_we` out 1: 1 = write, 0 = read
- `mem_addr` out addr_size: word-aligned address, [1:0] = 0
- `mem_wdata` out data_size: write data
- `mem_rdata` in data_size: read data, valid with `mem_ready`
- `mem_ready` in 1: one-cycle completion pulse

## Operation
- Address split: index = `M_Addr[index_bits+1:2]`; tag = `M_Addr[addr_size-1:index_bits+2]`.
- Arrays: valid bit, tag and data word per line. Hit = valid & tag match.
- FSM states: IDLE, RMISS, WMEM, WDONE.
- IDLE, load hit: `M_DM_Read_Data` = line data, combinational; `stall`=0.
- IDLE, load miss: `stall`=1; next state RMISS.
- IDLE, store: `stall`=1; next state WMEM.
- IDLE, neither: `stall`=0, `M_DM_Read_Data`=0.
- RMISS: `mem_req`=1, `mem_we`=0, `stall`=1. On `mem_ready`, write `mem_rdata`, tag and valid=1 into the line, then go to IDLE. The access re-evaluates as a hit on the next cycle.
- WMEM: `mem_req`=1, `mem_we`=1, `mem_wdata`=`M_Write_Data`, `stall`=1. On `mem_ready`, a hit line updates its data word; a missing line is left untouched (no allocate). Then go to WDONE.
- WDONE: `stall`=0 for exactly one cycle so the store retires, then go to IDLE. No new request is issued in this state.
- `M_MemRead` and `M_MemWrite` both high is illegal; the store takes priority.
- `mem_ready` in IDLE or WDONE is ignored.
- While `stall`=1, the pipeline holds `M_*` inputs stable.

## Timing
- Reset values:
  - FSM in IDLE; all valid bits = 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `stall`=0 and `M_DM_Read_Data`=0 while no access is present.
- `mem_*` outputs are registered. `stall` and `M_DM_Read_Data` are combinational from state, arrays and inputs.
- Load hit: 0 stall cycles.
- Load miss: `stall` is high from the detect cycle through the `mem_ready` cycle, then low on the following cycle (now a hit). Penalty = memory latency + 1.
- Store: `stall` high until the `mem_ready` cycle; next cycle is WDONE. Penalty = memory latency + 1.
- `mem_req` stays high, with address and data stable, until and including the `mem_ready` cycle. It drops the cycle after.
- Reset mid-miss or mid-write: the next posedge forces IDLE, `mem_req`=0 and all valid bits cleared. A later `mem_ready` is ignored.

## Configuration
- `DCACHE_STATS_EN` defined: adds 32-bit outputs `hit_count` and `miss_count`, both reset to 0.
  - `hit_count` increments once per load retired in IDLE with `stall`=0.
  - `miss_count` increments on each IDLE→RMISS transition.
  - Both wrap at 2^32.
- `DCACHE_STATS_EN` undefined: no counters and no count ports.

## Test plan
- Reset, then load 0x0040 with memory returning 0xDEADBEEF after 3 cycles → `stall` high for 4 cycles, `mem_addr`=0x0040, then `M_DM_Read_Data`=0xDEADBEEF with `stall`=0; a repeated load hits with 0 stalls.
- Store 0x1234 to cached 0x0040 → one `mem_req` with `mem_we`=1, then WDONE with `stall`=0; a following load of 0x0040 hits and returns 0x1234.
- Store to uncached 0x0080 → memory is written; a following load of 0x0080 misses (no allocate).
- Conflict: load 0x0040, then 0x0440 (same index, different tag), then 0x0040 → three misses; with `DCACHE_STATS_EN`, `miss_count`=3 and `hit_count`=3.
- Assert `rst` during RMISS, then pulse `mem_ready` → `mem_req`=0, FSM in IDLE, no line filled; a load of the same address misses again.
- `M_MemRead` and `M_MemWrite` both high at 0x0100 → treated as a store (`mem_we`=1).

Source files
------------

// File: rtl/dcache_mem_stage_if.sv
// Pipeline (EX/MEM -> MEM/WB) and backing-memory signals of the MEM-stage data cache.
// The cache uses the slave modport; the pipeline/memory side uses the master modport.
interface dcache_mem_stage_if #(
  parameter int unsigned data_size = 32,
  parameter int unsigned addr_size = 16
);
  logic                 M_MemRead;
  logic                 M_MemWrite;
  logic [addr_size-1:0] M_Addr;
  logic [data_size-1:0] M_Write_Data;
  logic [data_size-1:0] M_DM_Read_Data;
  logic                 stall;
  logic                 mem_req;
  logic                 mem_we;
  logic [addr_size-1:0] mem_addr;
  logic [data_size-1:0] mem_wdata;
  logic [data_size-1:0] mem_rdata;
  logic                 mem_ready;

  modport slave (
    input  M_MemRead, M_MemWrite, M_Addr, M_Write_Data, mem_rdata, mem_ready,
    output M_DM_Read_Data, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output M_MemRead, M_MemWrite, M_Addr, M_Write_Data, mem_rdata, mem_ready,
    input  M_DM_Read_Data, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache controller.
// Define DCACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module dcache_mem_stage #(
  parameter int unsigned data_size  = 32,
  parameter int unsigned addr_size  = 16,
  parameter int unsigned index_bits = 4
) (
  input  logic                clk,
  input  logic                rst,
  dcache_mem_stage_if.slave   bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int unsigned LINES = 1 << index_bits;
  localparam int unsigned TAG_W = addr_size - index_bits - 2;

  typedef enum logic [1:0] {IDLE, RMISS, WMEM, WDONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [LINES-1:0]       r_valid;
  logic [TAG_W-1:0]       r_tag  [LINES];
  logic [data_size-1:0]   r_data [LINES];
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [addr_size-1:0]   r_mem_addr;
  logic [data_size-1:0]   r_mem_wdata;

  logic [index_bits-1:0]  w_index;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_stall;
  logic [data_size-1:0]   w_rdata;
  logic                   w_fill;
  logic                   w_wupd;
  logic                   w_unused;

  assign w_index  = bus.M_Addr[index_bits+1:2];
  assign w_tag    = bus.M_Addr[addr_size-1:index_bits+2];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_unused = ^bus.M_Addr[1:0];

  // Next state, stall and load data; store wins when both requests are high.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_rdata = '0;
    w_fill  = 1'b0;
    w_wupd  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.M_MemWrite) begin
          w_stall = 1'b1;
          w_next  = WMEM;
        end else if (bus.M_MemRead) begin
          if (w_hit) begin
            w_rdata = r_data[w_index];
          end else begin
            w_stall = 1'b1;
            w_next  = RMISS;
          end
        end
      end
      RMISS: begin
        w_stall = 1'b1;
        if (bus.mem_ready) begin
          w_fill = 1'b1;
          w_next = IDLE;
        end
      end
      WMEM: begin
        w_stall = 1'b1;
        if (bus.mem_ready) begin
          w_wupd = w_hit;
          w_next = WDONE;
        end
      end
      WDONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, valid bits and registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (w_next == RMISS) || (w_next == WMEM);
      r_mem_we  <= (w_next == WMEM);
      if (w_fill) r_valid[w_index] <= 1'b1;
      if ((r_state == IDLE) && (w_next != IDLE))
        r_mem_addr <= {bus.M_Addr[addr_size-1:2], 2'b00};
      if ((r_state == IDLE) && (w_next == WMEM))
        r_mem_wdata <= bus.M_Write_Data;
    end
  end

  // Tag/data arrays need no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= bus.mem_rdata;
      end else if (w_wupd) begin
        r_data[w_index] <= bus.M_Write_Data;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((r_state == IDLE) && bus.M_MemRead && !bus.M_MemWrite && w_hit)
        hit_count <= hit_count + 32'd1;
      if ((r_state == IDLE) && (w_next == RMISS))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign bus.stall          = w_stall;
  assign bus.M_DM_Read_Data = w_rdata;
  assign bus.mem_req        = r_mem_req;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Self-checking bench for dcache_mem_stage: per-cycle vector table plus
// hand-written miss/conflict/reset sequences with a bounded memory responder.
module tb_dcache_mem_stage;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  dcache_mem_stage_if #(.data_size(32), .addr_size(16)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  dcache_mem_stage dut (.clk(clk), .rst(rst), .bus(bus),
                        .hit_count(hit_count), .miss_count(miss_count));
`else
  dcache_mem_stage dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] a;
    logic [31:0] wd;
    bit          rdy;
    logic [31:0] rdat;
    bit          e_stall;
    logic [31:0] e_rd;
    bit          e_req;
    bit          e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit rd, bit wr, logic [15:0] a, logic [31:0] wd,
                              bit rdy, logic [31:0] rdat, bit e_stall,
                              logic [31:0] e_rd, bit e_req, bit e_we,
                              logic [15:0] e_addr, logic [31:0] e_wd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.rdy = rdy; v.rdat = rdat;
    v.e_stall = e_stall; v.e_rd = e_rd; v.e_req = e_req; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive_idle();
    bus.M_MemRead    = 1'b0;
    bus.M_MemWrite   = 1'b0;
    bus.M_Addr       = 16'h0;
    bus.M_Write_Data = 32'h0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'h0;
  endtask

  // Load with a memory that answers on the lat-th request cycle; counts stall cycles.
  task automatic do_load(input logic [15:0] a, input logic [31:0] mdata, input int lat,
                         input logic [31:0] exp_d, input int exp_stalls, input string nm);
    int stalls = 0;
    int reqc   = 0;
    bit done   = 1'b0;
    bus.M_MemRead = 1'b1;
    bus.M_Addr    = a;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (!bus.stall) begin
        chk({nm, "_data"}, bus.M_DM_Read_Data, exp_d);
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.mem_req) begin
          reqc++;
          if (reqc == lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mdata;
          end
        end
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    drive_idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif

    // rd wr addr wdata rdy rdata | stall rdata req we mem_addr mem_wdata
    vq.push_back(mk(0,0,16'h0000,32'h0,        0,32'h0,        0,32'h0,        0,0,16'h0000,32'h0));
    vq.push_back(mk(1,0,16'h0040,32'h0,        0,32'h0,        1,32'h0,        0,0,16'h0000,32'h0));
    vq.push_back(mk(1,0,16'h0040,32'h0,        0,32'h0,        1,32'h0,        1,0,16'h0040,32'h0));
    vq.push_back(mk(1,0,16'h0040,32'h0,        0,32'h0,        1,32'h0,        1,0,16'h0040,32'h0));
    vq.push_back(mk(1,0,16'h0040,32'h0,        1,32'hDEADBEEF, 1,32'h0,        1,0,16'h0040,32'h0));
    vq.push_back(mk(1,0,16'h0040,32'h0,        0,32'h0,        0,32'hDEADBEEF, 0,0,16'h0040,32'h0));
    vq.push_back(mk(1,0,16'h0040,32'h0,        0,32'h0,        0,32'hDEADBEEF, 0,0,16'h0040,32'h0));
    vq.push_back(mk(0,0,16'h0000,32'h0,        0,32'h0,        0,32'h0,        0,0,16'h0040,32'h0));
    vq.push_back(mk(0,1,16'h0040,32'h1234,     0,32'h0,        1,32'h0,        0,0,16'h0040,32'h0));
    vq.push_back(mk(0,1,16'h0040,32'h1234,     0,32'h0,        1,32'h0,        1,1,16'h0040,32'h1234));
    vq.push_back(mk(0,1,16'h0040,32'h1234,     1,32'h0,        1,32'h0,        1,1,16'h0040,32'h1234));
    vq.push_back(mk(0,1,16'h0040,32'h1234,     0,32'h0,        0,32'h0,        0,0,16'h0040,32'h1234));
    vq.push_back(mk(1,0,16'h0040,32'h0,        0,32'h0,        0,32'h1234,     0,0,16'h0040,32'h1234));
    vq.push_back(mk(0,1,16'h0080,32'hCAFE0080, 0,32'h0,        1,32'h0,        0,0,16'h0040,32'h1234));
    vq.push_back(mk(0,1,16'h0080,32'hCAFE0080, 1,32'h0,        1,32'h0,        1,1,16'h0080,32'hCAFE0080));
    vq.push_back(mk(0,1,16'h0080,32'hCAFE0080, 0,32'h0,        0,32'h0,        0,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(1,0,16'h0080,32'h0,        0,32'h0,        1,32'h0,        0,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(1,0,16'h0080,32'h0,        1,32'h55AA55AA, 1,32'h0,        1,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(1,0,16'h0080,32'h0,        0,32'h0,        0,32'h55AA55AA, 0,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(0,0,16'h0000,32'h0,        1,32'hBAD0BAD0, 0,32'h0,        0,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(1,0,16'h0080,32'h0,        0,32'h0,        0,32'h55AA55AA, 0,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(1,1,16'h0100,32'h0BADF00D, 0,32'h0,        1,32'h0,        0,0,16'h0080,32'hCAFE0080));
    vq.push_back(mk(1,1,16'h0100,32'h0BADF00D, 1,32'h0,        1,32'h0,        1,1,16'h0100,32'h0BADF00D));
    vq.push_back(mk(1,1,16'h0100,32'h0BADF00D, 0,32'h0,        0,32'h0,        0,0,16'h0100,32'h0BADF00D));
    vq.push_back(mk(0,0,16'h0000,32'h0,        0,32'h0,        0,32'h0,        0,0,16'h0100,32'h0BADF00D));

    foreach (vq[i]) begin
      bus.M_MemRead    = vq[i].rd;
      bus.M_MemWrite   = vq[i].wr;
      bus.M_Addr       = vq[i].a;
      bus.M_Write_Data = vq[i].wd;
      bus.mem_ready    = vq[i].rdy;
      bus.mem_rdata    = vq[i].rdat;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vq[i].e_stall));
      chk($sformatf("v%0d_rdata", i), bus.M_DM_Read_Data, vq[i].e_rd);
      chk($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(vq[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(vq[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vq[i].e_addr));
      chk($sformatf("v%0d_wdata", i), bus.mem_wdata, vq[i].e_wd);
      @(negedge clk);
    end
    drive_idle();

    // Conflict: same index, different tags -> three misses, three retiring hits.
    begin
`ifdef DCACHE_STATS_EN
      logic [31:0] h0, m0;
      h0 = hit_count;
      m0 = miss_count;
`endif
      do_load(16'h0040, 32'hA0A0A0A0, 2, 32'hA0A0A0A0, 3, "cf1");
      do_load(16'h0440, 32'hB1B1B1B1, 1, 32'hB1B1B1B1, 2, "cf2");
      do_load(16'h0040, 32'hC2C2C2C2, 3, 32'hC2C2C2C2, 4, "cf3");
`ifdef DCACHE_STATS_EN
      chk("cf_hits", hit_count - h0, 32'd3);
      chk("cf_misses", miss_count - m0, 32'd3);
`endif
      do_load(16'h0040, 32'h0, 1, 32'hC2C2C2C2, 0, "cf_rehit");
    end

    // Reset during RMISS, then a stale mem_ready.
    bus.M_MemRead = 1'b1;
    bus.M_Addr    = 16'h0044;
    #1;
    chk("rm_detect_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    #1;
    chk("rm_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.M_MemRead = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h77777777;
    #1;
    chk("rm_req_after_rst", 32'(bus.mem_req), 32'd0);
    chk("rm_stall_after_rst", 32'(bus.stall), 32'd0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("rm_req_idle", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    do_load(16'h0044, 32'h44444444, 2, 32'h44444444, 3, "rm_reload");
    do_load(16'h0040, 32'h11111111, 1, 32'h11111111, 2, "rm_valid_clr");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
